// File: rtl/xcorr_lag.sv
// xcorr_lag: captures WIN sample pairs from two microphones, then sweeps the
// time-domain cross-correlation over lags -MAXLAG..+MAXLAG one MAC per cycle
// and reports the lag (and value) of the correlation peak.
`timescale 1ns/1ps
module xcorr_lag #(
  parameter int unsigned DW     = 16,
  parameter int unsigned WIN    = 256,
  parameter int unsigned MAXLAG = 31,
  parameter int unsigned ACCW   = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_vld,
  input  logic [DW-1:0]   mic_a,
  input  logic [DW-1:0]   mic_b,
  output logic [5:0]      lag,
  output logic [ACCW-1:0] peak,
  output logic            lag_vld,
  output logic            busy
);

  localparam int unsigned AW = $clog2(WIN);
  localparam int unsigned KW = 6;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned IW = AW + 2;

  localparam logic [KW-1:0] K_MIN  = KW'(-int'(MAXLAG));
  localparam logic [KW-1:0] K_MAX  = KW'(MAXLAG);
  localparam logic [AW-1:0] N_LAST = AW'(WIN - 1);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Sample storage; contents are don't-care after reset.
  logic [DW-1:0] buf_a [WIN];
  logic [DW-1:0] buf_b [WIN];

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;

  // Slot issue counters: k = lag, n = sample index within the lag.
  logic            issue_q, issue_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   n_q, n_d;

  // Stage 1: registered buffer read.
  logic            s1_vld_q, s1_vld_d;
  logic            s1_last_q, s1_last_d;
  logic            s1_first_q, s1_first_d;
  logic            s1_final_q, s1_final_d;
  logic [KW-1:0]   s1_k_q, s1_k_d;
  logic [DW-1:0]   a_rd_q, a_rd_d;
  logic [DW-1:0]   b_rd_q, b_rd_d;

  // Stage 2: registered full-width signed product.
  logic            s2_vld_q, s2_vld_d;
  logic            s2_last_q, s2_last_d;
  logic            s2_first_q, s2_first_d;
  logic            s2_final_q, s2_final_d;
  logic [KW-1:0]   s2_k_q, s2_k_d;
  logic [PW-1:0]   prod_q, prod_d;

  // Stage 3: accumulator and best-so-far tracker.
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] best_q, best_d;
  logic [KW-1:0]   best_lag_q, best_lag_d;

  // Drain delay between the final compare and the DONE cycle.
  logic            pend1_q, pend1_d;
  logic            pend2_q, pend2_d;

  // Registered outputs.
  logic [5:0]      lag_q, lag_d;
  logic [ACCW-1:0] peak_q, peak_d;
  logic            lag_vld_q, lag_vld_d;
  logic            busy_q, busy_d;

  logic            wr_en_c;
  logic [IW-1:0]   idx_c;
  logic            in_range_c;
  logic [ACCW-1:0] prod_ext_c;
  logic [ACCW-1:0] sum_c;

  assign wr_en_c    = (state_q == ST_CAPTURE) && sample_vld;
  assign idx_c      = {2'b00, n_q} + {{(IW - KW){k_q[KW-1]}}, k_q};
  assign in_range_c = (idx_c[IW-1:AW] == 2'b00);
  assign prod_ext_c = {{(ACCW - PW){prod_q[PW-1]}}, prod_q};
  assign sum_c      = acc_q + prod_ext_c;

  // Frame capture into the sample buffers.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buf_a[wr_cnt_q] <= mic_a;
      buf_b[wr_cnt_q] <= mic_b;
    end
  end

  // Next-state, MAC pipeline and peak-search logic.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    issue_d    = issue_q;
    k_d        = k_q;
    n_d        = n_q;
    lag_d      = lag_q;
    peak_d     = peak_q;
    lag_vld_d  = 1'b0;
    acc_d      = acc_q;
    best_d     = best_q;
    best_lag_d = best_lag_q;
    pend1_d    = 1'b0;
    pend2_d    = pend1_q;

    // Slot issue: one (k, n) pair per cycle, out-of-range slots included.
    if (issue_q) begin
      n_d = n_q + AW'(1);
      if (n_q == N_LAST) begin
        n_d = '0;
        if (k_q == K_MAX) begin
          issue_d = 1'b0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
    end

    s1_vld_d   = issue_q;
    s1_last_d  = issue_q && (n_q == N_LAST);
    s1_first_d = (k_q == K_MIN);
    s1_final_d = issue_q && (n_q == N_LAST) && (k_q == K_MAX);
    s1_k_d     = k_q;
    a_rd_d     = issue_q ? buf_a[n_q] : '0;
    b_rd_d     = (issue_q && in_range_c) ? buf_b[idx_c[AW-1:0]] : '0;

    s2_vld_d   = s1_vld_q;
    s2_last_d  = s1_last_q;
    s2_first_d = s1_first_q;
    s2_final_d = s1_final_q;
    s2_k_d     = s1_k_q;
    prod_d     = $signed(a_rd_q) * $signed(b_rd_q);

    // Accumulate; at the end of a lag compare against best and clear.
    if (s2_vld_q) begin
      if (s2_last_q) begin
        acc_d = '0;
        if (s2_first_q || ($signed(sum_c) > $signed(best_q))) begin
          best_d     = sum_c;
          best_lag_d = s2_k_q;
        end
        pend1_d = s2_final_q;
      end else begin
        acc_d = sum_c;
      end
    end

    case (state_q)
      ST_CAPTURE: begin
        if (sample_vld) begin
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (wr_cnt_q == N_LAST) begin
            wr_cnt_d = '0;
            state_d  = ST_COMPUTE;
            issue_d  = 1'b1;
            k_d      = K_MIN;
            n_d      = '0;
          end
        end
      end
      ST_COMPUTE: begin
        if (pend2_q) begin
          state_d   = ST_DONE;
          lag_vld_d = 1'b1;
          lag_d     = best_lag_q;
          peak_d    = best_q;
        end
      end
      ST_DONE: begin
        state_d = ST_CAPTURE;
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase

    busy_d = (state_d != ST_CAPTURE);
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CAPTURE;
      wr_cnt_q   <= '0;
      issue_q    <= 1'b0;
      k_q        <= '0;
      n_q        <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_final_q <= 1'b0;
      s1_k_q     <= '0;
      a_rd_q     <= '0;
      b_rd_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_first_q <= 1'b0;
      s2_final_q <= 1'b0;
      s2_k_q     <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_lag_q <= '0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      lag_q      <= '0;
      peak_q     <= '0;
      lag_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      issue_q    <= issue_d;
      k_q        <= k_d;
      n_q        <= n_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_first_q <= s1_first_d;
      s1_final_q <= s1_final_d;
      s1_k_q     <= s1_k_d;
      a_rd_q     <= a_rd_d;
      b_rd_q     <= b_rd_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      s2_first_q <= s2_first_d;
      s2_final_q <= s2_final_d;
      s2_k_q     <= s2_k_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_lag_q <= best_lag_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      lag_q      <= lag_d;
      peak_q     <= peak_d;
      lag_vld_q  <= lag_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign lag     = lag_q;
  assign peak    = peak_q;
  assign lag_vld = lag_vld_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_xcorr_lag.sv
// Bench for xcorr_lag: directed frames with random noise, compared against a
// direct-summation cross-correlation model. Uses WIN=64 to keep run time short.
`timescale 1ns/1ps
module tb_xcorr_lag;

  localparam int unsigned DW     = 16;
  localparam int unsigned WIN    = 64;
  localparam int unsigned MAXLAG = 31;
  localparam int unsigned ACCW   = 48;
  localparam int          LAT    = (2 * MAXLAG + 1) * WIN + 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_vld;
  logic [DW-1:0]   mic_a;
  logic [DW-1:0]   mic_b;
  logic [5:0]      lag;
  logic [ACCW-1:0] peak;
  logic            lag_vld;
  logic            busy;

  int     checks   = 0;
  int     failures = 0;
  int     a_arr [WIN];
  int     b_arr [WIN];
  int     src   [128];
  longint m_lag;
  longint m_peak;

  xcorr_lag #(.DW(DW), .WIN(WIN), .MAXLAG(MAXLAG), .ACCW(ACCW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_vld (sample_vld),
    .mic_a      (mic_a),
    .mic_b      (mic_b),
    .lag        (lag),
    .peak       (peak),
    .lag_vld    (lag_vld),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint lag_s();
    return longint'($signed(lag));
  endfunction

  function automatic longint peak_s();
    return longint'($signed(peak));
  endfunction

  // mic_b is mic_a delayed by d samples (negative d = advanced).
  task automatic fill_delay(input int d);
    for (int i = 0; i < 128; i++) src[i] = int'($signed(16'($urandom)));
    for (int n = 0; n < int'(WIN); n++) begin
      a_arr[n] = src[n + 20];
      b_arr[n] = src[n + 20 - d];
    end
  endtask

  // Reference: brute-force R(k) for every lag, first maximum wins.
  function automatic void model();
    longint r;
    m_lag  = 0;
    m_peak = 0;
    for (int k = -int'(MAXLAG); k <= int'(MAXLAG); k++) begin
      r = 0;
      for (int n = 0; n < int'(WIN); n++) begin
        if (n + k >= 0 && n + k < int'(WIN))
          r += longint'(a_arr[n]) * longint'(b_arr[n + k]);
      end
      if (k == -int'(MAXLAG) || r > m_peak) begin
        m_lag  = k;
        m_peak = r;
      end
    end
  endfunction

  // Send one frame (gap idle cycles between strobes), then watch the result.
  // junk: strobes driven during COMPUTE; abort_at: cycle to pulse reset (0 = none).
  task automatic run_frame(input string tag, input int gap, input int junk, input int abort_at);
    int              cyc;
    int              pulses;
    int              vld_cyc;
    bit              got;
    bit              stable;
    logic [5:0]      lag_before;
    logic [ACCW-1:0] peak_before;
    model();
    lag_before  = lag;
    peak_before = peak;
    for (int i = 0; i < int'(WIN); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          sample_vld = 1'b0;
          mic_a      = DW'($urandom);
          mic_b      = DW'($urandom);
        end
      end
      @(negedge clk);
      sample_vld = 1'b1;
      mic_a      = DW'(a_arr[i]);
      mic_b      = DW'(b_arr[i]);
    end
    cyc     = 0;
    pulses  = 0;
    vld_cyc = 0;
    got     = 1'b0;
    stable  = 1'b1;
    while (cyc < LAT + 20) begin
      @(negedge clk);
      cyc++;
      sample_vld = (cyc <= junk);
      mic_a      = DW'($urandom);
      mic_b      = DW'($urandom);
      if (cyc == 1) check({tag, "_busy_rise"}, longint'(busy), 1);
      if (abort_at > 0 && cyc == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_lag"},  lag_s(),  0);
        check({tag, "_rst_peak"}, peak_s(), 0);
        check({tag, "_rst_vld"},  longint'(lag_vld), 0);
        check({tag, "_rst_busy"}, longint'(busy), 0);
        @(negedge clk);
        rst        = 1'b0;
        sample_vld = 1'b0;
        for (int c = 0; c < LAT + 20; c++) begin
          @(negedge clk);
          if (lag_vld) pulses++;
        end
        check({tag, "_no_vld_after_rst"}, longint'(pulses), 0);
        check({tag, "_idle_busy"}, longint'(busy), 0);
        return;
      end
      if (lag_vld) begin
        pulses++;
        if (!got) begin
          got     = 1'b1;
          vld_cyc = cyc;
          check({tag, "_latency"}, longint'(cyc - 1), longint'(LAT));
          check({tag, "_lag"},  lag_s(),  m_lag);
          check({tag, "_peak"}, peak_s(), m_peak);
        end
      end else if (!got) begin
        if (lag !== lag_before || peak !== peak_before) stable = 1'b0;
      end
      if (got && cyc == vld_cyc + 1) begin
        check({tag, "_busy_fall"}, longint'(busy), 0);
      end
    end
    check({tag, "_outputs_held"}, longint'(stable), 1);
    check({tag, "_pulse_count"}, longint'(pulses), 1);
  endtask

  initial begin
    rst        = 1'b1;
    sample_vld = 1'b0;
    mic_a      = '0;
    mic_b      = '0;
    repeat (3) @(negedge clk);
    check("reset_lag",  lag_s(),  0);
    check("reset_peak", peak_s(), 0);
    check("reset_vld",  longint'(lag_vld), 0);
    check("reset_busy", longint'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill_delay(5);
    run_frame("delay5", 0, 0, 0);
    check("delay5_const", lag_s(), 5);

    fill_delay(-12);
    run_frame("adv12", 0, 0, 0);
    check("adv12_const", lag_s(), -12);

    for (int n = 0; n < int'(WIN); n++) begin
      a_arr[n] = n - 32;
      b_arr[n] = n - 32;
    end
    run_frame("ramp", 0, 0, 0);
    check("ramp_lag_const",  lag_s(),  0);
    check("ramp_peak_const", peak_s(), 21856);

    for (int n = 0; n < int'(WIN); n++) begin
      a_arr[n] = 0;
      b_arr[n] = 0;
    end
    run_frame("zero", 0, 0, 0);
    check("zero_lag_const",  lag_s(),  -31);
    check("zero_peak_const", peak_s(), 0);

    fill_delay(3);
    run_frame("abort", 0, 0, 2000);

    fill_delay(3);
    run_frame("after_rst", 0, 0, 0);
    check("after_rst_const", lag_s(), 3);

    fill_delay(7);
    run_frame("gap7", 2, 100, 0);
    check("gap7_const", lag_s(), 7);

    fill_delay(2);
    run_frame("post_junk", 0, 0, 0);
    check("post_junk_const", lag_s(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
